// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared HD44780 bus types, timing defaults and RS encodings
// Purpose: state enumeration for the read engine, default phase lengths in
//          50 MHz clock cycles, register-select encodings used by both the
//          reader and the write driver, and the phase-counter load helper.
// Ports:   none (package)
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EHIGH,
    ST_HOLD,
    ST_RECOV,
    ST_FINISH
  } lcd_rd_state_t;

  // Phase lengths in clock cycles; one full read cycle is 50 cycles (1 us).
  localparam int LCD_T_SETUP  = 8;
  localparam int LCD_T_EHIGH  = 25;
  localparam int LCD_T_HOLD   = 2;
  localparam int LCD_T_RECOV  = 15;
  localparam int LCD_POLL_MAX = 4095;

  // Wide enough for the longest phase (E high).
  localparam int LCD_PHASE_W  = 5;

  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  // The phase counter terminates at zero, so a phase of N cycles loads N-1.
  function automatic logic [LCD_PHASE_W-1:0] phase_load(input int cycles);
    return LCD_PHASE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/lcd_phase_counter.sv
// rtl/lcd_phase_counter.sv - loadable down-counter timing each bus phase
// Purpose: reloaded by the FSM on every state entry; tc_o marks the last
//          cycle of the current phase.
// Ports:   clk_i      - clock
//          rst_ni     - asynchronous active-low reset
//          load_i     - reload strobe (state entry)
//          load_val_i - phase length minus one
//          tc_o       - terminal count, high while the count is zero
module lcd_phase_counter #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// rtl/lcd_bus_reader.sv - HD44780 read-cycle engine with busy-flag polling
// Purpose: performs one status/data read on the shared LCD bus, or repeats
//          status reads until BF clears (bounded by POLL_MAX).
// Ports:   iCLK_50MHZ, iRST_N      - clock, async active-low reset
//          iREQ, iRS, iPOLL        - start pulse and latched request options
//          iDATA                   - LCD data pins from the pad
//          oBUS_OWN                - reader owns the LCD pins
//          LCD_RS, LCD_RW, LCD_E   - LCD control pins
//          oDATA, oBF, oAC         - last read byte, busy flag, address counter
//          oBUSY, oDONE, oTIMEOUT  - operation status
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int T_SETUP  = LCD_T_SETUP,
  parameter int T_EHIGH  = LCD_T_EHIGH,
  parameter int T_HOLD   = LCD_T_HOLD,
  parameter int T_RECOV  = LCD_T_RECOV,
  parameter int POLL_MAX = LCD_POLL_MAX
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST_N,
  input  logic       iREQ,
  input  logic       iRS,
  input  logic       iPOLL,
  input  logic [7:0] iDATA,
  output logic       oBUS_OWN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] oDATA,
  output logic       oBF,
  output logic [6:0] oAC,
  output logic       oBUSY,
  output logic       oDONE,
  output logic       oTIMEOUT
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam logic [CNT_W-1:0] POLL_LIMIT = CNT_W'(POLL_MAX);

  lcd_rd_state_t          state_q, state_d;
  logic                   phase_load_en;
  logic [LCD_PHASE_W-1:0] phase_val;
  logic                   phase_tc;

  logic             rs_q, poll_q, own_q, busy_q, rw_q, e_q, done_q, timeout_q, bf_q;
  logic [7:0]       data_q;
  logic [6:0]       ac_q;
  logic [CNT_W-1:0] poll_cnt_q;
  logic             repoll;

  lcd_phase_counter #(.W(LCD_PHASE_W)) u_phase (
    .clk_i      (iCLK_50MHZ),
    .rst_ni     (iRST_N),
    .load_i     (phase_load_en),
    .load_val_i (phase_val),
    .tc_o       (phase_tc)
  );

  // The count is never incremented past the limit, so it cannot wrap.
  assign repoll = poll_q && bf_q && (poll_cnt_q < POLL_LIMIT);

  always_comb begin
    state_d       = state_q;
    phase_load_en = 1'b0;
    phase_val     = '0;
    case (state_q)
      ST_IDLE: if (iREQ) begin
        state_d = ST_SETUP; phase_load_en = 1'b1; phase_val = phase_load(T_SETUP);
      end
      ST_SETUP: if (phase_tc) begin
        state_d = ST_EHIGH; phase_load_en = 1'b1; phase_val = phase_load(T_EHIGH);
      end
      ST_EHIGH: if (phase_tc) begin
        state_d = ST_HOLD; phase_load_en = 1'b1; phase_val = phase_load(T_HOLD);
      end
      ST_HOLD: if (phase_tc) begin
        state_d = ST_RECOV; phase_load_en = 1'b1; phase_val = phase_load(T_RECOV);
      end
      ST_RECOV: if (phase_tc) begin
        if (repoll) begin
          state_d = ST_SETUP; phase_load_en = 1'b1; phase_val = phase_load(T_SETUP);
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are updated on the transition edge so they are valid for the
  // whole of the state they belong to.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_IDLE;
      rs_q       <= LCD_RS_CMD;
      poll_q     <= 1'b0;
      own_q      <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      e_q        <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      bf_q       <= 1'b0;
      data_q     <= 8'h00;
      ac_q       <= 7'h00;
      poll_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: if (iREQ) begin
          rs_q       <= iRS;
          poll_q     <= iPOLL && (iRS == LCD_RS_CMD);  // polling only makes sense on status reads
          poll_cnt_q <= '0;
          timeout_q  <= 1'b0;
          own_q      <= 1'b1;
          busy_q     <= 1'b1;
          rw_q       <= 1'b1;
        end
        ST_SETUP: if (phase_tc) e_q <= 1'b1;
        ST_EHIGH: if (phase_tc) begin
          e_q    <= 1'b0;
          data_q <= iDATA;
          if (rs_q == LCD_RS_CMD) begin
            bf_q <= iDATA[7];
            ac_q <= iDATA[6:0];
          end
        end
        ST_RECOV: if (phase_tc) begin
          if (repoll) begin
            poll_cnt_q <= poll_cnt_q + CNT_W'(1);
          end else begin
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            own_q     <= 1'b0;
            rw_q      <= 1'b0;
            rs_q      <= LCD_RS_CMD;
            // Still busy here in poll mode means the re-read budget ran out.
            timeout_q <= poll_q && bf_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign oBUS_OWN = own_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = rw_q;
  assign LCD_E    = e_q;
  assign oDATA    = data_q;
  assign oBF      = bf_q;
  assign oAC      = ac_q;
  assign oBUSY    = busy_q;
  assign oDONE    = done_q;
  assign oTIMEOUT = timeout_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb/tb_lcd_bus_reader.sv - scoreboard bench for the LCD read engine
module tb_lcd_bus_reader;
  import lcd_pkg::*;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n, req_a, req_b, rs, poll, use_b;
  logic [7:0] din;

  logic       own_a, lrs_a, rw_a, e_a, bf_a, busy_a, done_a, to_a;
  logic [7:0] data_a;
  logic [6:0] ac_a;
  logic       own_b, lrs_b, rw_b, e_b, bf_b, busy_b, done_b, to_b;
  logic [7:0] data_b;
  logic [6:0] ac_b;

  lcd_bus_reader u_a (
    .iCLK_50MHZ(clk), .iRST_N(rst_n), .iREQ(req_a), .iRS(rs), .iPOLL(poll), .iDATA(din),
    .oBUS_OWN(own_a), .LCD_RS(lrs_a), .LCD_RW(rw_a), .LCD_E(e_a), .oDATA(data_a),
    .oBF(bf_a), .oAC(ac_a), .oBUSY(busy_a), .oDONE(done_a), .oTIMEOUT(to_a)
  );

  lcd_bus_reader #(.POLL_MAX(3)) u_b (
    .iCLK_50MHZ(clk), .iRST_N(rst_n), .iREQ(req_b), .iRS(rs), .iPOLL(poll), .iDATA(din),
    .oBUS_OWN(own_b), .LCD_RS(lrs_b), .LCD_RW(rw_b), .LCD_E(e_b), .oDATA(data_b),
    .oBF(bf_b), .oAC(ac_b), .oBUSY(busy_b), .oDONE(done_b), .oTIMEOUT(to_b)
  );

  logic       own_s, lrs_s, rw_s, e_s, bf_s, done_s, to_s;
  logic [7:0] data_s;
  logic [6:0] ac_s;
  assign own_s  = use_b ? own_b  : own_a;
  assign lrs_s  = use_b ? lrs_b  : lrs_a;
  assign rw_s   = use_b ? rw_b   : rw_a;
  assign e_s    = use_b ? e_b    : e_a;
  assign bf_s   = use_b ? bf_b   : bf_a;
  assign done_s = use_b ? done_b : done_a;
  assign to_s   = use_b ? to_b   : to_a;
  assign data_s = use_b ? data_b : data_a;
  assign ac_s   = use_b ? ac_b   : ac_a;

  int total = 0;
  int passed = 0;

  typedef struct {
    int         cycles;
    int         pulses;
    logic [7:0] data;
    logic       bf;
    logic [6:0] ac;
    logic       timeout;
  } exp_t;
  exp_t       sb[$];
  logic [7:0] rd_bytes[$];

  // Bench model of the result registers of instance A.
  logic       m_bf = 1'b0;
  logic [6:0] m_ac = 7'h00;

  int         o_cyc, o_pulses, o_emin, o_emax, o_setup;
  logic       o_stable, o_rs_hi, o_rs_lo, o_to2, o_bf, o_to;
  logic [7:0] o_data;
  logic [6:0] o_ac;

  // Issues one request and observes the bus until oDONE; cycle 1 is the iREQ cycle.
  task automatic run_op(input logic on_b, input logic rs_i, input logic poll_i,
                        input int x1, input int x2, input logic req_fin);
    int cyc, ehigh, last_chg;
    logic e_prev;
    logic [1:0] ctl_prev;
    use_b = on_b;
    @(negedge clk);
    rs = rs_i; poll = poll_i; din = rd_bytes[0];
    if (on_b) req_b = 1'b1; else req_a = 1'b1;
    cyc = 1; ehigh = 0; last_chg = 1; e_prev = 1'b0; ctl_prev = {lrs_s, rw_s};
    o_cyc = -1; o_pulses = 0; o_emin = 1000; o_emax = 0; o_setup = 1000;
    o_stable = 1'b1; o_rs_hi = 1'b1; o_rs_lo = 1'b1; o_to2 = 1'bx;
    while (cyc < 400 && o_cyc < 0) begin
      @(negedge clk);
      cyc++;
      req_a = 1'b0; req_b = 1'b0;
      if (cyc == x1 || cyc == x2) begin
        if (on_b) req_b = 1'b1; else req_a = 1'b1;
      end
      if (cyc == 2) o_to2 = to_s;
      if ({lrs_s, rw_s} !== ctl_prev) begin
        if (o_pulses > 0 && !done_s) o_stable = 1'b0;
        ctl_prev = {lrs_s, rw_s};
        last_chg = cyc;
      end
      if (own_s && !lrs_s) o_rs_hi = 1'b0;
      if (own_s && lrs_s)  o_rs_lo = 1'b0;
      if (e_s && !e_prev) begin
        o_pulses++;
        if (cyc - last_chg < o_setup) o_setup = cyc - last_chg;
        if (o_pulses > 1 && rd_bytes.size() > 1) void'(rd_bytes.pop_front());
        din = rd_bytes[0];
        ehigh = 0;
      end
      if (e_s) ehigh++;
      if (!e_s && e_prev) begin
        if (ehigh < o_emin) o_emin = ehigh;
        if (ehigh > o_emax) o_emax = ehigh;
      end
      e_prev = e_s;
      if (done_s) begin
        o_cyc = cyc; o_data = data_s; o_bf = bf_s; o_ac = ac_s; o_to = to_s;
        if (req_fin) begin
          if (on_b) req_b = 1'b1; else req_a = 1'b1;
        end
      end
    end
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; rs = 1'b0; poll = 1'b0; din = 8'h00; use_b = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({e_a, rw_a, lrs_a, own_a, busy_a, done_a, to_a, bf_a, data_a, ac_a} !== 23'h0)
      $display("FAIL reset_a: got %h expected 0", {e_a, rw_a, lrs_a, own_a, busy_a, done_a, to_a, bf_a, data_a, ac_a});
    else passed++;
    total++;
    if ({e_b, rw_b, lrs_b, own_b, busy_b, done_b, to_b, bf_b, data_b, ac_b} !== 23'h0)
      $display("FAIL reset_b: got %h expected 0", {e_b, rw_b, lrs_b, own_b, busy_b, done_b, to_b, bf_b, data_b, ac_b});
    else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_status_read;
    exp_t e;
    rd_bytes = '{8'h85};
    m_bf = 1'b1; m_ac = 7'h05;
    sb.push_back('{52, 1, 8'h85, m_bf, m_ac, 1'b0});
    run_op(1'b0, LCD_RS_CMD, 1'b0, 0, 0, 1'b0);
    e = sb.pop_front();
    total++; if (o_cyc !== e.cycles) $display("FAIL status_latency: got %0d expected %0d", o_cyc, e.cycles); else passed++;
    total++; if (o_pulses !== e.pulses) $display("FAIL status_pulses: got %0d expected %0d", o_pulses, e.pulses); else passed++;
    total++;
    if ({o_data, o_bf, o_ac, o_to} !== {e.data, e.bf, e.ac, e.timeout})
      $display("FAIL status_result: got %h expected %h", {o_data, o_bf, o_ac, o_to}, {e.data, e.bf, e.ac, e.timeout});
    else passed++;
    total++; if (o_emin !== 25 || o_emax !== 25) $display("FAIL status_ehigh: got %0d..%0d expected 25", o_emin, o_emax); else passed++;
    total++; if (o_setup < 8) $display("FAIL status_setup: got %0d expected >=8", o_setup); else passed++;
    total++; if (o_stable !== 1'b1 || o_rs_lo !== 1'b1) $display("FAIL status_ctl_stable: got %b%b expected 11", o_stable, o_rs_lo); else passed++;
  endtask

  task automatic test_data_read;
    exp_t e;
    rd_bytes = '{8'h41};
    sb.push_back('{52, 1, 8'h41, m_bf, m_ac, 1'b0});
    // Poll is requested but must be ignored for a data read.
    run_op(1'b0, LCD_RS_DATA, 1'b1, 0, 0, 1'b0);
    e = sb.pop_front();
    total++; if (o_cyc !== e.cycles) $display("FAIL data_latency: got %0d expected %0d", o_cyc, e.cycles); else passed++;
    total++;
    if ({o_pulses[7:0], o_data, o_bf, o_ac} !== {e.pulses[7:0], e.data, e.bf, e.ac})
      $display("FAIL data_result: got %h expected %h", {o_pulses[7:0], o_data, o_bf, o_ac}, {e.pulses[7:0], e.data, e.bf, e.ac});
    else passed++;
    total++; if (o_rs_hi !== 1'b1 || o_stable !== 1'b1) $display("FAIL data_rs_high: got %b%b expected 11", o_rs_hi, o_stable); else passed++;
  endtask

  task automatic test_poll;
    exp_t e;
    rd_bytes = '{8'h80, 8'h80, 8'h80, 8'h12};
    m_bf = 1'b0; m_ac = 7'h12;
    sb.push_back('{52 + 3 * 50, 4, 8'h12, m_bf, m_ac, 1'b0});
    run_op(1'b0, LCD_RS_CMD, 1'b1, 0, 0, 1'b0);
    e = sb.pop_front();
    total++; if (o_cyc !== e.cycles) $display("FAIL poll_latency: got %0d expected %0d", o_cyc, e.cycles); else passed++;
    total++; if (o_pulses !== e.pulses) $display("FAIL poll_pulses: got %0d expected %0d", o_pulses, e.pulses); else passed++;
    total++;
    if ({o_data, o_bf, o_ac, o_to} !== {e.data, e.bf, e.ac, e.timeout})
      $display("FAIL poll_result: got %h expected %h", {o_data, o_bf, o_ac, o_to}, {e.data, e.bf, e.ac, e.timeout});
    else passed++;
  endtask

  task automatic test_timeout;
    exp_t e;
    rd_bytes = '{8'hFF};
    sb.push_back('{52 + 3 * 50, 4, 8'hFF, 1'b1, 7'h7F, 1'b1});
    run_op(1'b1, LCD_RS_CMD, 1'b1, 0, 0, 1'b0);
    e = sb.pop_front();
    total++; if (o_pulses !== e.pulses) $display("FAIL timeout_pulses: got %0d expected %0d", o_pulses, e.pulses); else passed++;
    total++; if (o_cyc !== e.cycles) $display("FAIL timeout_latency: got %0d expected %0d", o_cyc, e.cycles); else passed++;
    total++;
    if ({o_data, o_bf, o_ac, o_to} !== {e.data, e.bf, e.ac, e.timeout})
      $display("FAIL timeout_result: got %h expected %h", {o_data, o_bf, o_ac, o_to}, {e.data, e.bf, e.ac, e.timeout});
    else passed++;
    rd_bytes = '{8'h00};
    sb.push_back('{52, 1, 8'h00, 1'b0, 7'h00, 1'b0});
    run_op(1'b1, LCD_RS_CMD, 1'b0, 0, 0, 1'b0);
    e = sb.pop_front();
    total++; if (o_to2 !== 1'b0) $display("FAIL timeout_clear: got %b expected 0", o_to2); else passed++;
    total++;
    if ({o_cyc[7:0], o_data, o_bf, o_ac, o_to} !== {e.cycles[7:0], e.data, e.bf, e.ac, e.timeout})
      $display("FAIL timeout_next_result: got %h expected %h", {o_cyc[7:0], o_data, o_bf, o_ac, o_to}, {e.cycles[7:0], e.data, e.bf, e.ac, e.timeout});
    else passed++;
  endtask

  task automatic test_ignored_req;
    exp_t e;
    int extra;
    rd_bytes = '{8'h33};
    m_bf = 1'b0; m_ac = 7'h33;
    sb.push_back('{52, 1, 8'h33, m_bf, m_ac, 1'b0});
    run_op(1'b0, LCD_RS_CMD, 1'b0, 10, 30, 1'b1);
    e = sb.pop_front();
    total++;
    if ({o_cyc[7:0], o_pulses[7:0], o_data} !== {e.cycles[7:0], e.pulses[7:0], e.data})
      $display("FAIL ignored_req_op: got %h expected %h", {o_cyc[7:0], o_pulses[7:0], o_data}, {e.cycles[7:0], e.pulses[7:0], e.data});
    else passed++;
    extra = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy_a || done_a || e_a) extra++;
    end
    total++; if (extra !== 0) $display("FAIL ignored_req_quiet: got %0d active cycles expected 0", extra); else passed++;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [7:0] bytes[3];
    logic       rsel[3];
    bytes = '{8'h07, 8'hC3, 8'h9A};
    rsel  = '{LCD_RS_CMD, LCD_RS_DATA, LCD_RS_CMD};
    for (int i = 0; i < 3; i++) begin
      rd_bytes = '{bytes[i]};
      if (rsel[i] == LCD_RS_CMD) begin
        m_bf = bytes[i][7]; m_ac = bytes[i][6:0];
      end
      sb.push_back('{52, 1, bytes[i], m_bf, m_ac, 1'b0});
      run_op(1'b0, rsel[i], 1'b0, 0, 0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({o_cyc[7:0], o_data, o_bf, o_ac} !== {e.cycles[7:0], e.data, e.bf, e.ac})
        $display("FAIL back_to_back_%0d: got %h expected %h", i, {o_cyc[7:0], o_data, o_bf, o_ac}, {e.cycles[7:0], e.data, e.bf, e.ac});
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int dones;
    dones = 0;
    use_b = 1'b0;
    @(negedge clk);
    rs = LCD_RS_CMD; poll = 1'b0; din = 8'h55; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    repeat (14) @(negedge clk);
    total++; if (e_a !== 1'b1) $display("FAIL reset_mid_in_ehigh: got %b expected 1", e_a); else passed++;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({e_a, own_a, busy_a, rw_a} !== 4'b0000)
      $display("FAIL reset_mid_async: got %b expected 0000", {e_a, own_a, busy_a, rw_a});
    else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    total++;
    if (dones !== 0 || data_a !== 8'h00)
      $display("FAIL reset_mid_no_done: got dones=%0d data=%h expected 0 00", dones, data_a);
    else passed++;
    rst_n = 1'b1;
    rd_bytes = '{8'h2A};
    m_bf = 1'b0; m_ac = 7'h2A;
    sb.push_back('{52, 1, 8'h2A, m_bf, m_ac, 1'b0});
    run_op(1'b0, LCD_RS_CMD, 1'b0, 0, 0, 1'b0);
    e = sb.pop_front();
    total++;
    if ({o_cyc[7:0], o_data, o_bf, o_ac, o_to} !== {e.cycles[7:0], e.data, e.bf, e.ac, e.timeout})
      $display("FAIL reset_mid_recover: got %h expected %h", {o_cyc[7:0], o_data, o_bf, o_ac, o_to}, {e.cycles[7:0], e.data, e.bf, e.ac, e.timeout});
    else passed++;
  endtask

  initial begin
    test_reset;
    test_status_read;
    test_data_read;
    test_poll;
    test_timeout;
    test_ignored_req;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog: simulation exceeded 20000 cycles");
    $fatal(1);
  end

endmodule
